layer_compositor: RTL and testbench
===================================

LAYER_COMPOSITOR -- requirements
Module: layer_compositor

Interface
REQ-001 Parameter NUM_SPRITES, default 8, number of sprite channels; channel 0 is the character.
REQ-002 Parameter SCREEN_WIDTH, default 10, width of x/y pixel counters.
REQ-003 Parameter PHY_WIDTH, default 14, width of absolute world coordinates and camera offset.
REQ-004 Parameter PIXEL_WIDTH, default 12, RGB word width.
REQ-005 Parameter SIZE_WIDTH, default 6, width of sprite width/height fields.
REQ-006 Parameter BG_COLOR, default 12'hFFF, colour where no sprite hits.
REQ-007 sys_clk  input  1  single clock; one cycle per pixel.
REQ-008 sys_rst_n  input  1  reset, asynchronous, active-low.
REQ-009 video_on  input  1  active-video flag from the VGA controller.
REQ-010 x, y  input  SCREEN_WIDTH each  current screen pixel.
REQ-011 frame_start  input  1  one-cycle pulse before the first active pixel of each frame.
REQ-012 camera_offset  input  PHY_WIDTH  world-y of screen row 0.
REQ-013 cfg_we  input  1  sprite configuration write strobe.
REQ-014 cfg_idx  input  clog2(NUM_SPRITES)  channel being written.
REQ-015 cfg_x, cfg_y  input  PHY_WIDTH each  sprite top-left (x screen, y world).
REQ-016 cfg_w, cfg_h  input  SIZE_WIDTH each  sprite size in pixels.
REQ-017 cfg_color  input  PIXEL_WIDTH  sprite fill colour; cfg_enable  input  1  channel enable.
REQ-018 rgb  output  PIXEL_WIDTH  registered pixel colour; rgb_valid  output  1  delayed video_on.
REQ-019 collision  output  NUM_SPRITES  bit k set = channel 0 overlapped channel k last frame; bit 0 always 0.
REQ-020 collision_valid  output  1  one-cycle pulse when collision updates.

Function
REQ-021 Each channel SHALL hold a shadow register set written on cfg_we and an active set used for drawing.
REQ-022 On frame_start all active sets and the latched camera offset SHALL load from shadow/camera_offset in one cycle.
REQ-023 cfg_we coincident with frame_start SHALL update shadow only; the write becomes active at the next frame_start.
REQ-024 cfg_we with cfg_idx >= NUM_SPRITES SHALL be ignored.
REQ-025 Stage 1 SHALL register per-channel hit = enable && x>=sx && x<sx+w && (y+cam)>=sy && (y+cam)<sy+h, computed in PHY_WIDTH+1 bits with no wrap-around.
REQ-026 w=0 or h=0 SHALL never hit.
REQ-027 Stage 2 SHALL select the lowest-index hitting channel's colour; no hit gives BG_COLOR; delayed video_on low gives 0.
REQ-028 Latency SHALL be exactly 2 cycles: rgb/rgb_valid at cycle n+2 correspond to x,y,video_on at cycle n.
REQ-029 During a frame, a sticky bit k SHALL set on any pixel with video_on and stage-1 hits on both channel 0 and channel k (k>=1).
REQ-030 On frame_start, collision SHALL take the sticky value, collision_valid SHALL pulse, and sticky SHALL clear; a hit pixel in that same cycle counts toward the new frame.

Reset
REQ-031 While sys_rst_n low: rgb=0, rgb_valid=0, collision=0, collision_valid=0, all shadow/active enables=0, latched camera=0, sticky=0, pipeline cleared.
REQ-032 Reset mid-frame SHALL discard partial collision history; first frame_start after reset reports collision=0.

Structure
REQ-033 Shared package SHALL hold the colour constants and the default width parameters.
REQ-034 One sub-module sprite_hit (single-channel bound compare) SHALL be instantiated NUM_SPRITES times.

Verification
REQ-035 Channel 0 at (100,50) 32x32 colour 12'h00F, cam=0, frame_start; x=100,y=50 -> rgb=12'h00F two cycles later; x=132 -> BG_COLOR.
REQ-036 Channels 0 and 3 overlapping at (200,200) -> rgb shows channel 0 colour; next frame_start -> collision=8'b0000_1000, collision_valid one cycle.
REQ-037 cfg_we moving channel 1 on the same cycle as frame_start -> old position drawn this frame, new position after the following frame_start.
REQ-038 cam=480, sprite cfg_y=500 -> hit at screen y=20, no hit at y=19; sprite cfg_y=16380 with h=32 -> no wrap hit at y+cam small.
REQ-039 video_on low for a pixel inside a sprite -> rgb=0, rgb_valid=0 two cycles later.
REQ-040 Assert sys_rst_n low mid-frame with sticky set -> all outputs 0 immediately; next frame_start -> collision=0.

Source files
------------

// File: rtl/layer_compositor_pkg.sv
// Shared constants and default widths for the layer compositor.
package layer_compositor_pkg;

  localparam int unsigned DefNumSprites  = 8;
  localparam int unsigned DefScreenWidth = 10;
  localparam int unsigned DefPhyWidth    = 14;
  localparam int unsigned DefPixelWidth  = 12;
  localparam int unsigned DefSizeWidth   = 6;

  localparam logic [DefPixelWidth-1:0] ColorWhite = 12'hFFF;
  localparam logic [DefPixelWidth-1:0] ColorBlack = 12'h000;

endpackage

// File: rtl/sprite_hit.sv
// Single-channel rectangle bound compare; coordinates carry one guard bit so
// the right/bottom edges never wrap past the world size.
module sprite_hit
  import layer_compositor_pkg::*;
#(
  parameter int unsigned PHY_WIDTH  = DefPhyWidth,
  parameter int unsigned SIZE_WIDTH = DefSizeWidth
) (
  input  logic                 enable_i,
  input  logic [PHY_WIDTH:0]   px_i,
  input  logic [PHY_WIDTH:0]   py_i,
  input  logic [PHY_WIDTH-1:0] sx_i,
  input  logic [PHY_WIDTH-1:0] sy_i,
  input  logic [SIZE_WIDTH-1:0] w_i,
  input  logic [SIZE_WIDTH-1:0] h_i,
  output logic                 hit_o
);

  localparam int unsigned ExtWidth = PHY_WIDTH + 1;

  logic [PHY_WIDTH:0] sx_ext, sy_ext, x_end, y_end;

  assign sx_ext = {1'b0, sx_i};
  assign sy_ext = {1'b0, sy_i};
  assign x_end  = sx_ext + ExtWidth'(w_i);
  assign y_end  = sy_ext + ExtWidth'(h_i);

  // A zero width/height makes the half-open interval empty.
  assign hit_o = enable_i && (px_i >= sx_ext) && (px_i < x_end) &&
                 (py_i >= sy_ext) && (py_i < y_end);

endmodule

// File: rtl/layer_compositor.sv
// Two-stage sprite compositor: stage 1 registers per-channel hits, stage 2
// picks the lowest-index colour. Tracks channel-0 collisions per frame.
module layer_compositor
  import layer_compositor_pkg::*;
#(
  parameter int unsigned NUM_SPRITES  = DefNumSprites,
  parameter int unsigned SCREEN_WIDTH = DefScreenWidth,
  parameter int unsigned PHY_WIDTH    = DefPhyWidth,
  parameter int unsigned PIXEL_WIDTH  = DefPixelWidth,
  parameter int unsigned SIZE_WIDTH   = DefSizeWidth,
  parameter logic [PIXEL_WIDTH-1:0] BG_COLOR = PIXEL_WIDTH'(ColorWhite),
  localparam int unsigned IdxWidth = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1
) (
  input  logic                    sys_clk,
  input  logic                    sys_rst_n,
  input  logic                    video_on,
  input  logic [SCREEN_WIDTH-1:0] x,
  input  logic [SCREEN_WIDTH-1:0] y,
  input  logic                    frame_start,
  input  logic [PHY_WIDTH-1:0]    camera_offset,
  input  logic                    cfg_we,
  input  logic [IdxWidth-1:0]     cfg_idx,
  input  logic [PHY_WIDTH-1:0]    cfg_x,
  input  logic [PHY_WIDTH-1:0]    cfg_y,
  input  logic [SIZE_WIDTH-1:0]   cfg_w,
  input  logic [SIZE_WIDTH-1:0]   cfg_h,
  input  logic [PIXEL_WIDTH-1:0]  cfg_color,
  input  logic                    cfg_enable,
  output logic [PIXEL_WIDTH-1:0]  rgb,
  output logic                    rgb_valid,
  output logic [NUM_SPRITES-1:0]  collision,
  output logic                    collision_valid
);

  localparam int unsigned ExtWidth = PHY_WIDTH + 1;

  logic [PHY_WIDTH-1:0]   sh_x_q     [NUM_SPRITES];
  logic [PHY_WIDTH-1:0]   sh_y_q     [NUM_SPRITES];
  logic [SIZE_WIDTH-1:0]  sh_w_q     [NUM_SPRITES];
  logic [SIZE_WIDTH-1:0]  sh_h_q     [NUM_SPRITES];
  logic [PIXEL_WIDTH-1:0] sh_color_q [NUM_SPRITES];
  logic [NUM_SPRITES-1:0] sh_en_q;

  logic [PHY_WIDTH-1:0]   act_x_q     [NUM_SPRITES];
  logic [PHY_WIDTH-1:0]   act_y_q     [NUM_SPRITES];
  logic [SIZE_WIDTH-1:0]  act_w_q     [NUM_SPRITES];
  logic [SIZE_WIDTH-1:0]  act_h_q     [NUM_SPRITES];
  logic [PIXEL_WIDTH-1:0] act_color_q [NUM_SPRITES];
  logic [NUM_SPRITES-1:0] act_en_q;
  logic [PHY_WIDTH-1:0]   cam_q;

  logic [PHY_WIDTH:0]     px, py;
  logic [NUM_SPRITES-1:0] hit_d, hit_q;
  logic                   vid1_q;
  logic [PIXEL_WIDTH-1:0] pix_d, rgb_q;
  logic                   rgb_valid_q;
  logic [NUM_SPRITES-1:0] coll_hits, sticky_d, sticky_q, collision_q;
  logic                   collision_valid_q;
  logic                   cfg_ok;

  assign cfg_ok = cfg_we && (32'(cfg_idx) < NUM_SPRITES);

  // Shadow writes land regardless of frame_start; the active copy below
  // samples the pre-write shadow, deferring a coincident write by one frame.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      for (int i = 0; i < NUM_SPRITES; i++) begin
        sh_x_q[i]      <= '0;
        sh_y_q[i]      <= '0;
        sh_w_q[i]      <= '0;
        sh_h_q[i]      <= '0;
        sh_color_q[i]  <= '0;
        act_x_q[i]     <= '0;
        act_y_q[i]     <= '0;
        act_w_q[i]     <= '0;
        act_h_q[i]     <= '0;
        act_color_q[i] <= '0;
      end
      sh_en_q  <= '0;
      act_en_q <= '0;
      cam_q    <= '0;
    end else begin
      if (cfg_ok) begin
        sh_x_q[cfg_idx]     <= cfg_x;
        sh_y_q[cfg_idx]     <= cfg_y;
        sh_w_q[cfg_idx]     <= cfg_w;
        sh_h_q[cfg_idx]     <= cfg_h;
        sh_color_q[cfg_idx] <= cfg_color;
        sh_en_q[cfg_idx]    <= cfg_enable;
      end
      if (frame_start) begin
        for (int i = 0; i < NUM_SPRITES; i++) begin
          act_x_q[i]     <= sh_x_q[i];
          act_y_q[i]     <= sh_y_q[i];
          act_w_q[i]     <= sh_w_q[i];
          act_h_q[i]     <= sh_h_q[i];
          act_color_q[i] <= sh_color_q[i];
        end
        act_en_q <= sh_en_q;
        cam_q    <= camera_offset;
      end
    end
  end

  assign px = ExtWidth'(x);
  assign py = ExtWidth'(y) + {1'b0, cam_q};

  for (genvar g = 0; g < NUM_SPRITES; g++) begin : gen_hit
    sprite_hit #(
      .PHY_WIDTH  (PHY_WIDTH),
      .SIZE_WIDTH (SIZE_WIDTH)
    ) u_sprite_hit (
      .enable_i (act_en_q[g]),
      .px_i     (px),
      .py_i     (py),
      .sx_i     (act_x_q[g]),
      .sy_i     (act_y_q[g]),
      .w_i      (act_w_q[g]),
      .h_i      (act_h_q[g]),
      .hit_o    (hit_d[g])
    );
  end

  // Descending scan so the lowest-index hitting channel wins.
  always_comb begin
    pix_d = BG_COLOR;
    for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
      if (hit_q[i]) pix_d = act_color_q[i];
    end
    if (!vid1_q) pix_d = PIXEL_WIDTH'(ColorBlack);
  end

  always_comb begin
    coll_hits = '0;
    for (int k = 1; k < NUM_SPRITES; k++) begin
      coll_hits[k] = vid1_q && hit_q[0] && hit_q[k];
    end
    // Hits arriving on the frame_start cycle seed the next frame.
    sticky_d = frame_start ? coll_hits : (sticky_q | coll_hits);
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      hit_q             <= '0;
      vid1_q            <= 1'b0;
      rgb_q             <= '0;
      rgb_valid_q       <= 1'b0;
      sticky_q          <= '0;
      collision_q       <= '0;
      collision_valid_q <= 1'b0;
    end else begin
      hit_q             <= hit_d;
      vid1_q            <= video_on;
      rgb_q             <= pix_d;
      rgb_valid_q       <= vid1_q;
      sticky_q          <= sticky_d;
      collision_valid_q <= frame_start;
      if (frame_start) collision_q <= sticky_q;
    end
  end

  assign rgb             = rgb_q;
  assign rgb_valid       = rgb_valid_q;
  assign collision       = collision_q;
  assign collision_valid = collision_valid_q;

endmodule

// File: tb/tb_layer_compositor.sv
// Scoreboard bench for layer_compositor: directed pixels and frame pulses
// push expectations; a negedge monitor pops and compares them.
module tb_layer_compositor;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic        video_on = 1'b0;
  logic [9:0]  x = '0, y = '0;
  logic        frame_start = 1'b0;
  logic [13:0] camera_offset = '0;
  logic        cfg_we = 1'b0;
  logic [2:0]  cfg_idx = '0;
  logic [13:0] cfg_x = '0, cfg_y = '0;
  logic [5:0]  cfg_w = '0, cfg_h = '0;
  logic [11:0] cfg_color = '0;
  logic        cfg_enable = 1'b0;
  logic [11:0] rgb;
  logic        rgb_valid;
  logic [7:0]  collision;
  logic        collision_valid;

  layer_compositor dut (
    .sys_clk         (sys_clk),
    .sys_rst_n       (sys_rst_n),
    .video_on        (video_on),
    .x               (x),
    .y               (y),
    .frame_start     (frame_start),
    .camera_offset   (camera_offset),
    .cfg_we          (cfg_we),
    .cfg_idx         (cfg_idx),
    .cfg_x           (cfg_x),
    .cfg_y           (cfg_y),
    .cfg_w           (cfg_w),
    .cfg_h           (cfg_h),
    .cfg_color       (cfg_color),
    .cfg_enable      (cfg_enable),
    .rgb             (rgb),
    .rgb_valid       (rgb_valid),
    .collision       (collision),
    .collision_valid (collision_valid)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    int          cyc;
    logic        valid;
    logic [11:0] rgb;
    string       name;
  } pix_exp_t;

  pix_exp_t    pq[$];
  logic [7:0]  cq[$];
  pix_exp_t    me;
  int          cyc = 0;
  int          tests = 0;
  int          fails = 0;

  always @(posedge sys_clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pixel results are due exactly two cycles after issue.
  always @(negedge sys_clk) begin
    if (pq.size() > 0 && pq[0].cyc == cyc) begin
      me = pq.pop_front();
      check({me.name, " rgb_valid"}, 32'(rgb_valid), 32'(me.valid));
      check({me.name, " rgb"}, 32'(rgb), 32'(me.rgb));
    end
    if (collision_valid) begin
      if (cq.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL collision_valid: pulse with no pending frame_start, collision=%0h", collision);
      end else begin
        check("collision", 32'(collision), 32'(cq.pop_front()));
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge sys_clk);
      video_on = 1'b0; frame_start = 1'b0; cfg_we = 1'b0;
    end
  endtask

  task automatic pix(input int px, input int py, input logic von, input logic chk,
                     input logic [11:0] expv, input string name);
    @(negedge sys_clk);
    frame_start = 1'b0; cfg_we = 1'b0;
    video_on = von; x = 10'(px); y = 10'(py);
    if (chk) pq.push_back('{cyc + 2, von, von ? expv : 12'h000, name});
  endtask

  task automatic fs(input logic [7:0] ec);
    @(negedge sys_clk);
    video_on = 1'b0; cfg_we = 1'b0; frame_start = 1'b1;
    cq.push_back(ec);
  endtask

  task automatic cfg(input int idx, input int sx, input int sy, input int w, input int h,
                     input logic [11:0] col, input logic en, input logic with_fs,
                     input logic [7:0] ec);
    @(negedge sys_clk);
    video_on = 1'b0; frame_start = with_fs; cfg_we = 1'b1;
    cfg_idx = 3'(idx); cfg_x = 14'(sx); cfg_y = 14'(sy);
    cfg_w = 6'(w); cfg_h = 6'(h); cfg_color = col; cfg_enable = en;
    if (with_fs) cq.push_back(ec);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge sys_clk);
    check("reset rgb", 32'(rgb), 0);
    check("reset rgb_valid", 32'(rgb_valid), 0);
    check("reset collision", 32'(collision), 0);
    check("reset collision_valid", 32'(collision_valid), 0);
    sys_rst_n = 1'b1;
    idle(2);

    // Basic single sprite
    cfg(0, 100, 50, 32, 32, 12'h00F, 1'b1, 1'b0, 8'h00);
    fs(8'h00);
    pix(100, 50, 1'b1, 1'b1, 12'h00F, "ch0 top-left");
    pix(132, 50, 1'b1, 1'b1, 12'hFFF, "ch0 right edge+1");
    pix(131, 81, 1'b1, 1'b1, 12'h00F, "ch0 bottom-right");
    pix(131, 82, 1'b1, 1'b1, 12'hFFF, "ch0 bottom edge+1");
    pix(99, 50, 1'b1, 1'b1, 12'hFFF, "ch0 left edge-1");
    idle(2);

    // Overlap channels 0 and 3 -> priority and collision
    cfg(3, 200, 200, 16, 16, 12'h0F0, 1'b1, 1'b0, 8'h00);
    cfg(0, 200, 200, 32, 32, 12'h00F, 1'b1, 1'b0, 8'h00);
    fs(8'h00);
    pix(200, 200, 1'b1, 1'b1, 12'h00F, "overlap priority a");
    pix(215, 215, 1'b1, 1'b1, 12'h00F, "overlap priority b");
    pix(216, 216, 1'b1, 1'b1, 12'h00F, "ch0 only");
    pix(199, 200, 1'b1, 1'b1, 12'hFFF, "left of overlap");
    pix(232, 200, 1'b1, 1'b1, 12'hFFF, "right of ch0");
    idle(2);
    fs(8'h08);
    fs(8'h00);

    // Config write coincident with frame_start is deferred one frame
    cfg(1, 400, 100, 8, 8, 12'hF00, 1'b1, 1'b0, 8'h00);
    fs(8'h00);
    cfg(1, 500, 100, 8, 8, 12'hF00, 1'b1, 1'b1, 8'h00);
    pix(400, 100, 1'b1, 1'b1, 12'hF00, "deferred old pos");
    pix(500, 100, 1'b1, 1'b1, 12'hFFF, "deferred new pos not yet");
    idle(2);
    fs(8'h00);
    pix(400, 100, 1'b1, 1'b1, 12'hFFF, "moved old pos");
    pix(500, 100, 1'b1, 1'b1, 12'hF00, "moved new pos");
    idle(2);

    // Camera offset
    camera_offset = 14'd480;
    cfg(2, 600, 500, 8, 8, 12'h0FF, 1'b1, 1'b0, 8'h00);
    fs(8'h00);
    pix(600, 20, 1'b1, 1'b1, 12'h0FF, "cam hit y20");
    pix(600, 19, 1'b1, 1'b1, 12'hFFF, "cam miss y19");
    pix(600, 27, 1'b1, 1'b1, 12'h0FF, "cam hit y27");
    pix(600, 28, 1'b1, 1'b1, 12'hFFF, "cam miss y28");
    idle(2);

    // Sprite near the world top must not wrap to small y
    cfg(4, 700, 16380, 8, 32, 12'hABC, 1'b1, 1'b0, 8'h00);
    camera_offset = 14'd0;
    fs(8'h00);
    pix(700, 10, 1'b1, 1'b1, 12'hFFF, "no wrap y10");
    pix(700, 27, 1'b1, 1'b1, 12'hFFF, "no wrap y27");
    pix(700, 0, 1'b1, 1'b1, 12'hFFF, "no wrap y0");
    idle(2);
    camera_offset = 14'd16370;
    fs(8'h00);
    pix(700, 10, 1'b1, 1'b1, 12'hABC, "world top hit");
    pix(700, 9, 1'b1, 1'b1, 12'hFFF, "world top miss");
    pix(707, 13, 1'b1, 1'b1, 12'hABC, "world top last");
    pix(708, 13, 1'b1, 1'b1, 12'hFFF, "world top x+w");
    idle(2);
    camera_offset = 14'd0;

    // Zero size and disabled channels never hit
    cfg(5, 800, 100, 0, 8, 12'h123, 1'b1, 1'b0, 8'h00);
    cfg(6, 820, 100, 8, 8, 12'h456, 1'b0, 1'b0, 8'h00);
    cfg(7, 840, 100, 8, 0, 12'h789, 1'b1, 1'b0, 8'h00);
    fs(8'h00);
    pix(800, 100, 1'b1, 1'b1, 12'hFFF, "w=0");
    pix(820, 100, 1'b1, 1'b1, 12'hFFF, "disabled");
    pix(840, 100, 1'b1, 1'b1, 12'hFFF, "h=0");
    pix(500, 100, 1'b1, 1'b1, 12'hF00, "ch1 still drawn");
    idle(2);

    // Blanking inside a sprite
    pix(205, 205, 1'b0, 1'b1, 12'h000, "video off");
    idle(2);

    // Mid-frame reset with sticky set
    pix(205, 205, 1'b1, 1'b1, 12'h00F, "pre-reset overlap");
    idle(2);
    fs(8'h08);
    pix(205, 205, 1'b1, 1'b0, 12'h000, "");
    pix(205, 205, 1'b1, 1'b0, 12'h000, "");
    pix(205, 205, 1'b1, 1'b0, 12'h000, "");
    @(negedge sys_clk);
    sys_rst_n = 1'b0;
    #1;
    check("mid reset rgb", 32'(rgb), 0);
    check("mid reset rgb_valid", 32'(rgb_valid), 0);
    check("mid reset collision", 32'(collision), 0);
    check("mid reset collision_valid", 32'(collision_valid), 0);
    video_on = 1'b0;
    idle(2);
    sys_rst_n = 1'b1;
    idle(1);
    fs(8'h00);
    pix(205, 205, 1'b1, 1'b1, 12'hFFF, "post-reset cleared cfg");
    idle(4);

    check("scoreboard drained", 32'(pq.size() + cq.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
